// File: rtl/nrisc_idata_loader.sv
// Program loader for the NRISC IData programming port: parses framed byte stream,
// writes 16-bit words at auto-incrementing addresses and holds the core while loading.
module nrisc_idata_loader #(
  parameter int N_IData     = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        IDATA_PROG_write,
  output logic [9:0]  IDATA_PROG_addr,
  output logic [15:0] IDATA_PROG_data,
  output logic        core_hold,
  output logic        load_done,
  output logic        err_chk,
  output logic        err_range,
  output logic        err_tmo
);

  localparam logic [7:0]  SYNC     = 8'hA5;
  localparam logic [16:0] DEPTH    = 17'(1) << N_IData;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L, S_WRITE, S_CHK
  } state_t;

  state_t               r_state, w_next;
  logic [15:0]          r_addr;
  logic [7:0]           r_cnt_h;
  logic [15:0]          r_rem;
  logic [N_IData-1:0]   r_wptr;
  logic [7:0]           r_word_h;
  logic [7:0]           r_xor;
  logic [15:0]          r_tmo;
  logic                 r_write;
  logic [9:0]           r_paddr;
  logic [15:0]          r_pdata;
  logic                 r_hold, r_done, r_echk, r_erange, r_etmo;

  logic        w_acc;
  logic        w_tmo;
  logic [15:0] w_cnt;
  logic        w_range_bad;

  assign rx_ready    = (r_state != S_WRITE);
  assign w_acc       = rx_valid & rx_ready;
  assign w_cnt       = {r_cnt_h, rx_data};
  // 17-bit sum so an address near 0xFFFF cannot wrap past the depth check
  assign w_range_bad = ({1'b0, r_addr} + {1'b0, w_cnt}) > DEPTH;
  assign w_tmo       = (r_state != S_IDLE) && !w_acc && (r_tmo == TMO_LAST);

  assign IDATA_PROG_write = r_write;
  assign IDATA_PROG_addr  = r_paddr;
  assign IDATA_PROG_data  = r_pdata;
  assign core_hold        = r_hold;
  assign load_done        = r_done;
  assign err_chk          = r_echk;
  assign err_range        = r_erange;
  assign err_tmo          = r_etmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_tmo) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_acc && rx_data == SYNC) w_next = S_ADDR_H;
        S_ADDR_H: if (w_acc) w_next = S_ADDR_L;
        S_ADDR_L: if (w_acc) w_next = S_CNT_H;
        S_CNT_H:  if (w_acc) w_next = S_CNT_L;
        S_CNT_L:
          if (w_acc) begin
            if (w_range_bad)        w_next = S_IDLE;
            else if (w_cnt == '0)   w_next = S_CHK;
            else                    w_next = S_DATA_H;
          end
        S_DATA_H: if (w_acc) w_next = S_DATA_L;
        S_DATA_L: if (w_acc) w_next = S_WRITE;
        S_WRITE:  w_next = (r_rem == 16'd1) ? S_CHK : S_DATA_H;
        S_CHK:    if (w_acc) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_cnt_h  <= '0;
      r_rem    <= '0;
      r_wptr   <= '0;
      r_word_h <= '0;
      r_xor    <= '0;
      r_tmo    <= '0;
      r_write  <= 1'b0;
      r_paddr  <= '0;
      r_pdata  <= '0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
      r_echk   <= 1'b0;
      r_erange <= 1'b0;
      r_etmo   <= 1'b0;
    end else begin
      r_write  <= 1'b0;
      r_done   <= 1'b0;
      r_echk   <= 1'b0;
      r_erange <= 1'b0;
      r_etmo   <= w_tmo;

      // idle gap counter; an accepted byte always beats expiry
      if (r_state == S_IDLE || w_acc || w_tmo) r_tmo <= '0;
      else                                     r_tmo <= r_tmo + 16'd1;

      if (r_state == S_WRITE) begin
        r_wptr <= r_wptr + 1'b1;
        r_rem  <= r_rem - 16'd1;
      end

      if (w_acc) begin
        case (r_state)
          S_IDLE:
            if (rx_data == SYNC) begin
              r_hold <= 1'b1;
              r_xor  <= '0;
            end
          S_ADDR_H: begin r_addr[15:8] <= rx_data; r_xor <= r_xor ^ rx_data; end
          S_ADDR_L: begin r_addr[7:0]  <= rx_data; r_xor <= r_xor ^ rx_data; end
          S_CNT_H:  begin r_cnt_h      <= rx_data; r_xor <= r_xor ^ rx_data; end
          S_CNT_L: begin
            r_xor <= r_xor ^ rx_data;
            if (w_range_bad) begin
              r_erange <= 1'b1;
            end else begin
              r_wptr <= r_addr[N_IData-1:0];
              r_rem  <= w_cnt;
            end
          end
          S_DATA_H: begin r_word_h <= rx_data; r_xor <= r_xor ^ rx_data; end
          S_DATA_L: begin
            r_xor   <= r_xor ^ rx_data;
            r_write <= 1'b1;
            r_paddr <= 10'(r_wptr);
            r_pdata <= {r_word_h, rx_data};
          end
          S_CHK:
            if (rx_data == r_xor) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_echk <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrisc_idata_loader.sv
// Scoreboard bench for nrisc_idata_loader: a frame-level reference model queues the
// expected writes and status pulses; a negedge monitor pops and compares them.
module tb_nrisc_idata_loader;
  localparam int TMO   = 16;
  localparam int DEPTH = 1024;
  localparam int K_WR = 0, K_DONE = 1, K_ECHK = 2, K_ERANGE = 3, K_ETMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        IDATA_PROG_write;
  logic [9:0]  IDATA_PROG_addr;
  logic [15:0] IDATA_PROG_data;
  logic        core_hold, load_done, err_chk, err_range, err_tmo;

  nrisc_idata_loader #(.N_IData(10), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .IDATA_PROG_write(IDATA_PROG_write), .IDATA_PROG_addr(IDATA_PROG_addr),
    .IDATA_PROG_data(IDATA_PROG_data), .core_hold(core_hold), .load_done(load_done),
    .err_chk(err_chk), .err_range(err_range), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int addr; int data; } ev_t;
  ev_t        exp_q[$];
  logic [7:0] frame_q[$];
  int         tests = 0;
  int         fails = 0;
  bit         exp_hold = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int a, input int d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input int a, input int d);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected: got kind %0d addr 0x%0h data 0x%0h, expected no event", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_WR && (e.addr != a || e.data != d))) begin
        fails++;
        $display("FAIL sb_event: got kind %0d addr 0x%0h data 0x%0h expected kind %0d addr 0x%0h data 0x%0h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // monitor: every write strobe and status pulse must match the next expected event
  always @(negedge clk) begin
    if (rst) begin
      if (IDATA_PROG_write) check_ev(K_WR, int'(IDATA_PROG_addr), int'(IDATA_PROG_data));
      if ((int'(load_done) + int'(err_chk) + int'(err_range) + int'(err_tmo)) > 1) begin
        tests++; fails++;
        $display("FAIL multi_pulse: got done %0b chk %0b range %0b tmo %0b, expected at most one",
                 load_done, err_chk, err_range, err_tmo);
      end else if (load_done) check_ev(K_DONE, 0, 0);
      else if (err_chk)       check_ev(K_ECHK, 0, 0);
      else if (err_range)     check_ev(K_ERANGE, 0, 0);
      else if (err_tmo)       check_ev(K_ETMO, 0, 0);
    end
  end

  // reference model over a whole frame in frame_q (starting at 0xA5); returns bytes consumed
  task automatic model_frame(output int nsend);
    int a, c, x;
    a = {frame_q[1], frame_q[2]};
    c = {frame_q[3], frame_q[4]};
    exp_hold = 1'b1;
    if (a + c > DEPTH) begin
      push_ev(K_ERANGE, 0, 0);
      nsend = 5;
      return;
    end
    for (int i = 0; i < c; i++) push_ev(K_WR, a + i, {frame_q[5 + 2*i], frame_q[6 + 2*i]});
    x = 0;
    for (int i = 1; i < 5 + 2*c; i++) x = x ^ frame_q[i];
    if (frame_q[5 + 2*c] == x) begin
      push_ev(K_DONE, 0, 0);
      exp_hold = 1'b0;
    end else begin
      push_ev(K_ECHK, 0, 0);
    end
    nsend = 6 + 2*c;
  endtask

  task automatic make_frame(input int a, input int c, input bit good);
    logic [7:0] x, b;
    frame_q = {8'hA5, 8'(a >> 8), 8'(a), 8'(c >> 8), 8'(c)};
    for (int i = 0; i < 2*c; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    x = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) x = x ^ frame_q[i];
    b = 8'h01 << $urandom_range(0, 7);
    frame_q.push_back(good ? x : (x ^ b));
  endtask

  // called at a negedge; returns at the negedge after the byte was accepted
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 8) begin @(negedge clk); n++; end
    if (!rx_ready) begin
      tests++; fails++;
      $display("FAIL rx_ready_wait: got rx_ready 0 for %0d cycles, expected 1", n);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    int nsend;
    model_frame(nsend);
    for (int i = 0; i < nsend; i++) begin
      send(frame_q[i]);
      if (i == 0) chk("hold_after_sync", int'(core_hold), 1);
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk("sb_drain", exp_q.size(), 0);
    chk("core_hold", int'(core_hold), int'(exp_hold));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, int'(rx_ready), 1);
    chk({tag, "_write"}, int'(IDATA_PROG_write), 0);
    chk({tag, "_addr"}, int'(IDATA_PROG_addr), 0);
    chk({tag, "_data"}, int'(IDATA_PROG_data), 0);
    chk({tag, "_hold"}, int'(core_hold), 0);
    chk({tag, "_pulses"}, {28'd0, load_done, err_chk, err_range, err_tmo}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsend;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // basic two-word load
    frame_q = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h52};
    send_frame(0);
    drain();

    // bad checksum keeps hold, then a good frame releases it
    frame_q = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h53};
    send_frame(1);
    drain();
    frame_q = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h52};
    send_frame(0);
    drain();

    // range overflow by one word
    frame_q = {8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    drain();

    // junk in idle, then zero-count frame
    send(8'h11); send(8'h22);
    frame_q = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    drain();

    // timeout after exactly TMO idle cycles
    exp_hold = 1'b1;
    push_ev(K_ETMO, 0, 0);
    send(8'hA5); send(8'h00);
    repeat (TMO) @(negedge clk);
    chk("tmo_pulse", int'(err_tmo), 1);
    drain();

    // byte arriving on the expiring cycle wins
    frame_q = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h10};
    model_frame(nsend);
    send(frame_q[0]); send(frame_q[1]);
    repeat (TMO - 1) @(negedge clk);
    for (int i = 2; i < nsend; i++) send(frame_q[i]);
    drain();

    // reset mid-frame after first word's low byte
    exp_hold = 1'b1;
    push_ev(K_WR, 16'h020, 16'h1234);
    frame_q = {8'hA5, 8'h00, 8'h20, 8'h00, 8'h03, 8'h12, 8'h34};
    for (int i = 0; i < frame_q.size(); i++) send(frame_q[i]);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    exp_hold = 1'b0;
    chk("sb_after_reset", exp_q.size(), 0);
    @(negedge clk);

    // randomized frames, many near the top of memory
    for (int f = 0; f < 40; f++) begin
      int a, c;
      logic [7:0] j;
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h00;
        send(j);
      end
      c = $urandom_range(0, 5);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1019, 1023) : $urandom_range(0, 1023);
      make_frame(a, c, $urandom_range(0, 3) != 0);
      send_frame(2);
      drain();
    end

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
